// File: rtl/ide_pkg.sv
// Shared IDE register map, status bit values and transfer-sequencer state
// encoding used by the ide_xfer_sequencer slice.
package ide_pkg;

   localparam logic [3:0] REG_STATUS_IRQ = 4'd0;
   localparam logic [3:0] REG_ERROR      = 4'd1;
   localparam logic [3:0] REG_IOCONTROL  = 4'd2;
   localparam logic [3:0] REG_IOPOS      = 4'd3;
   localparam logic [3:0] REG_STATUS     = 4'd4;
   localparam logic [3:0] REG_IOTARGET   = 4'd5;
   localparam logic [3:0] REG_FLAGS      = 4'd6;

   localparam logic [7:0] BSY  = 8'h80;
   localparam logic [7:0] DRDY = 8'h40;
   localparam logic [7:0] DSC  = 8'h10;
   localparam logic [7:0] DRQ  = 8'h08;
   localparam logic [7:0] ERR  = 8'h01;
   localparam logic [7:0] ABRT = 8'h04;

   // The same flags bit is written to clear the data flag and read to see it.
   localparam logic [7:0] FLAG_DATA     = 8'h20;
   localparam int         FLAG_DATA_BIT = 5;

   typedef enum logic [3:0] {
      IDLE,
      SET_DIR,
      FILL,
      ARM_POS,
      ARM_TGT,
      ARM_CLR,
      ARM_STAT,
      WAIT_DATA,
      POST_BSY,
      DRAIN,
      FINISH,
      ABT_ERR,
      ABT_STAT
   } xfer_state_t;

endpackage

// File: rtl/ide_xfer_timer.sv
// WAIT_DATA watchdog for ide_xfer_sequencer; compiled only when
// IDE_XFER_TIMEOUT_EN is defined, so the default build carries no counter.
`ifdef IDE_XFER_TIMEOUT_EN
module ide_xfer_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_,
   input  logic clear,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] cnt;

   // Expires on the TIMEOUT_CYCLES-th cycle after clear drops, then holds.
   assign expired = (cnt == W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (!expired) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule
`endif

// File: rtl/ide_xfer_sequencer.sv
// Sequences IDE PIO block transfers through the register file and AVR buffer.
// Optional WAIT_DATA timeout: define IDE_XFER_TIMEOUT_EN.
module ide_xfer_sequencer
   import ide_pkg::*;
#(
   parameter int BLOCK_WORDS    = 256,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       start,
   input  logic       dir,
   input  logic [7:0] nblocks,
   input  logic       abort,
   input  logic       blk_ack,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       blk_ready,
   output logic [3:0] reg_a,
   output logic [7:0] reg_wd,
   output logic       reg_we,
   input  logic [7:0] reg_rdata
);

   localparam logic [7:0] IOTARGET = 8'(BLOCK_WORDS - 1);

   xfer_state_t state, state_nxt;
   logic        dir_q, dir_nxt;
   logic        first_q, first_nxt;
   logic [8:0]  cnt_q, cnt_nxt;
   logic        err_nxt;
   logic        busy_nxt, done_nxt, blk_ready_nxt, we_nxt;
   logic [3:0]  a_nxt;
   logic [7:0]  wd_nxt;
   logic        tmo;

`ifdef IDE_XFER_TIMEOUT_EN
   ide_xfer_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst_   (rst_),
      .clear  (state != WAIT_DATA),
      .expired(tmo)
   );
`else
   // TIMEOUT_CYCLES stays on the interface but can never fire here.
   assign tmo = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_nxt = state;
      dir_nxt   = dir_q;
      first_nxt = first_q;
      cnt_nxt   = cnt_q;
      err_nxt   = err;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SET_DIR;
               dir_nxt   = dir;
               first_nxt = 1'b1;
               cnt_nxt   = (nblocks == 8'd0) ? 9'd256 : {1'b0, nblocks};
               err_nxt   = 1'b0;
            end
         end
         SET_DIR:  state_nxt = dir_q ? ARM_POS : FILL;
         FILL:     if (blk_ack) state_nxt = ARM_POS;
         ARM_POS:  state_nxt = ARM_TGT;
         ARM_TGT:  state_nxt = ARM_CLR;
         ARM_CLR:  state_nxt = ARM_STAT;
         ARM_STAT: begin
            state_nxt = WAIT_DATA;
            first_nxt = 1'b0;
         end
         WAIT_DATA: begin
            if (reg_rdata[FLAG_DATA_BIT]) begin
               cnt_nxt = cnt_q - 9'd1;
               if (dir_q)                state_nxt = POST_BSY;
               else if (cnt_q != 9'd1)   state_nxt = FILL;
               else                      state_nxt = FINISH;
            end else if (tmo) begin
               state_nxt = ABT_ERR;
            end
         end
         POST_BSY: state_nxt = DRAIN;
         DRAIN:    if (blk_ack) state_nxt = (cnt_q != 9'd0) ? ARM_POS : FINISH;
         FINISH:   state_nxt = IDLE;
         ABT_ERR:  state_nxt = ABT_STAT;
         ABT_STAT: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase

      // Abort wins over ack, data flag and timeout; the abort path itself runs to completion.
      if (abort && !(state inside {IDLE, ABT_ERR, ABT_STAT})) begin
         state_nxt = ABT_ERR;
         cnt_nxt   = cnt_q;
      end

      // Outputs are decoded from the state being entered, then registered.
      busy_nxt      = (state_nxt != IDLE);
      done_nxt      = (state_nxt inside {FINISH, ABT_STAT});
      blk_ready_nxt = (state_nxt inside {FILL, DRAIN});
      if (state_nxt == ABT_STAT) err_nxt = 1'b1;

      we_nxt = 1'b0;
      a_nxt  = 4'd0;
      wd_nxt = 8'd0;
      unique case (state_nxt)
         SET_DIR: begin
            we_nxt = 1'b1; a_nxt = REG_IOCONTROL; wd_nxt = {7'b0, dir_nxt};
         end
         ARM_POS: begin
            we_nxt = 1'b1; a_nxt = REG_IOPOS; wd_nxt = 8'h00;
         end
         ARM_TGT: begin
            we_nxt = 1'b1; a_nxt = REG_IOTARGET; wd_nxt = IOTARGET;
         end
         ARM_CLR: begin
            we_nxt = 1'b1; a_nxt = REG_FLAGS; wd_nxt = FLAG_DATA;
         end
         ARM_STAT: begin
            // First host-to-device block is announced without an interrupt.
            we_nxt = 1'b1;
            a_nxt  = (dir_nxt && first_nxt) ? REG_STATUS : REG_STATUS_IRQ;
            wd_nxt = DRDY | DSC | DRQ;
         end
         WAIT_DATA: a_nxt = REG_FLAGS;
         POST_BSY: begin
            we_nxt = 1'b1; a_nxt = REG_STATUS; wd_nxt = BSY | DRDY | DSC;
         end
         FINISH: begin
            we_nxt = 1'b1;
            a_nxt  = dir_nxt ? REG_STATUS_IRQ : REG_STATUS;
            wd_nxt = DRDY | DSC;
         end
         ABT_ERR: begin
            we_nxt = 1'b1; a_nxt = REG_ERROR; wd_nxt = ABRT;
         end
         ABT_STAT: begin
            we_nxt = 1'b1; a_nxt = REG_STATUS_IRQ; wd_nxt = DRDY | DSC | ERR;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state     <= IDLE;
         dir_q     <= 1'b0;
         first_q   <= 1'b0;
         cnt_q     <= 9'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         blk_ready <= 1'b0;
         reg_we    <= 1'b0;
         reg_a     <= 4'd0;
         reg_wd    <= 8'd0;
      end else begin
         state     <= state_nxt;
         dir_q     <= dir_nxt;
         first_q   <= first_nxt;
         cnt_q     <= cnt_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         blk_ready <= blk_ready_nxt;
         reg_we    <= we_nxt;
         reg_a     <= a_nxt;
         reg_wd    <= wd_nxt;
      end
   end

endmodule

// File: tb/tb_ide_xfer_sequencer.sv
// Self-checking bench for ide_xfer_sequencer: random AVR/device response timing,
// expected register-write streams built from the transfer rules.
module tb_ide_xfer_sequencer;

   localparam int         BW  = 64;
   localparam int         TMO = 16;
   localparam logic [7:0] TGT = 8'(BW - 1);

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst_, start, dir, abort;
   logic [7:0] nblocks;
   logic       blk_ack = 1'b0;
   logic       busy, done, err, blk_ready, reg_we;
   logic [3:0] reg_a;
   logic [7:0] reg_wd, reg_rdata;

   logic       flag_resp = 1'b0;
   logic       flag_task = 1'b0;
   logic       resp_hold = 1'b0;
   logic [7:0] junk = 8'h00;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign reg_rdata = (reg_a == 4'd6) ? ((junk & 8'hDF) | {2'b00, flag_resp | flag_task, 5'b0}) : junk;

   ide_xfer_sequencer #(
      .BLOCK_WORDS   (BW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk      (clk),
      .rst_     (rst_),
      .start    (start),
      .dir      (dir),
      .nblocks  (nblocks),
      .abort    (abort),
      .blk_ack  (blk_ack),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .blk_ready(blk_ready),
      .reg_a    (reg_a),
      .reg_wd   (reg_wd),
      .reg_we   (reg_we),
      .reg_rdata(reg_rdata)
   );

   // Monitor: write log with cycle stamps, pulse/edge counters.
   wr_t  obs_q[$];
   int   obs_cyc[$];
   int   cyc = 0;
   int   done_cnt = 0, ready_rise = 0, wait_cycles = 0;
   logic ready_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reg_we) begin
         obs_q.push_back(wr_t'{a: reg_a, d: reg_wd});
         obs_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (blk_ready && !ready_prev) ready_rise++;
      ready_prev = blk_ready;
      if (reg_a == 4'd6 && !reg_we) wait_cycles++;
   end

   // AVR and device model with random service delays and stray acks.
   int exits = 0, ack_wait = 0, flag_wait = 0;

   always @(negedge clk) begin
      junk      = 8'($urandom);
      blk_ack   = 1'b0;
      flag_resp = 1'b0;
      if (blk_ready) begin
         if (ack_wait == 0) begin
            blk_ack  = 1'b1;
            ack_wait = $urandom_range(0, 3);
         end else ack_wait--;
      end else if ($urandom_range(0, 3) == 0) begin
         blk_ack = 1'b1;
      end
      if (reg_a == 4'd6 && !reg_we && !resp_hold) begin
         if (flag_wait == 0) begin
            flag_resp = 1'b1;
            flag_wait = $urandom_range(0, 3);
            exits++;
         end else flag_wait--;
      end
   end

   wr_t exp_q[$];

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic void build_abort_exp(input bit d);
      exp_q.delete();
      exp_q.push_back(wr_t'{a: 4'h2, d: {7'b0, d}});
      exp_q.push_back(wr_t'{a: 4'h3, d: 8'h00});
      exp_q.push_back(wr_t'{a: 4'h5, d: TGT});
      exp_q.push_back(wr_t'{a: 4'h6, d: 8'h20});
      exp_q.push_back(wr_t'{a: d ? 4'h4 : 4'h0, d: 8'h58});
      exp_q.push_back(wr_t'{a: 4'h1, d: 8'h04});
      exp_q.push_back(wr_t'{a: 4'h0, d: 8'h51});
   endfunction

   task automatic test_reset();
      rst_ = 1'b0; start = 1'b0; dir = 1'b0; nblocks = 8'd0; abort = 1'b0;
      repeat (3) step();
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      total++; if (blk_ready !== 1'b0) begin bad++; $display("FAIL reset_blk_ready got=%b want=0", blk_ready); end
      total++; if (reg_we !== 1'b0)    begin bad++; $display("FAIL reset_reg_we got=%b want=0", reg_we); end
      total++; if (reg_a !== 4'd0)     begin bad++; $display("FAIL reset_reg_a got=%h want=0", reg_a); end
      total++; if (reg_wd !== 8'd0)    begin bad++; $display("FAIL reset_reg_wd got=%h want=0", reg_wd); end
      rst_ = 1'b1;
      step();
   endtask

   task automatic test_abort_idle();
      int bw = obs_q.size();
      int bd = done_cnt;
      logic err0 = err;
      abort = 1'b1;
      repeat (3) step();
      abort = 1'b0;
      step();
      total++; if (busy !== 1'b0)          begin bad++; $display("FAIL idle_abort_busy got=%b want=0", busy); end
      total++; if (obs_q.size() != bw)     begin bad++; $display("FAIL idle_abort_writes got=%0d want=0", obs_q.size() - bw); end
      total++; if (done_cnt != bd)         begin bad++; $display("FAIL idle_abort_done got=%0d want=0", done_cnt - bd); end
      total++; if (err !== err0)           begin bad++; $display("FAIL idle_abort_err got=%b want=%b", err, err0); end
   endtask

   // Full transfer; also pulses start mid-transfer, which must be ignored.
   task automatic test_xfer(input bit d, input int n);
      int  ne = (n == 0) ? 256 : n;
      int  bw = obs_q.size();
      int  bd = done_cnt;
      int  bx = exits;
      int  br = ready_rise;
      int  c0, nw;
      bit  seen = 1'b0;
      exp_q.delete();
      exp_q.push_back(wr_t'{a: 4'h2, d: {7'b0, d}});
      for (int b = 0; b < ne; b++) begin
         exp_q.push_back(wr_t'{a: 4'h3, d: 8'h00});
         exp_q.push_back(wr_t'{a: 4'h5, d: TGT});
         exp_q.push_back(wr_t'{a: 4'h6, d: 8'h20});
         exp_q.push_back(wr_t'{a: (d && b == 0) ? 4'h4 : 4'h0, d: 8'h58});
         if (d) exp_q.push_back(wr_t'{a: 4'h4, d: 8'hD0});
      end
      exp_q.push_back(wr_t'{a: d ? 4'h0 : 4'h4, d: 8'h50});

      c0 = cyc;
      start = 1'b1; dir = d; nblocks = 8'(n);
      step();
      start = 1'b0; dir = ~d; nblocks = 8'($urandom);
      for (int k = 0; k < ne * 30 + 50 && !seen; k++) begin
         step();
         start = (k == 2);
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      total++;
      if (!seen) begin
         bad++; $display("FAIL xfer_timeout dir=%0d n=%0d got=no_done want=done", d, n);
      end else begin
         total++; if (err !== 1'b0) begin bad++; $display("FAIL xfer_err got=%b want=0", err); end
         step();
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL xfer_busy_after got=%b want=0", busy); end
      end
      repeat (3) step();

      nw = obs_q.size() - bw;
      total++; if (nw != exp_q.size()) begin bad++; $display("FAIL xfer_nwrites dir=%0d n=%0d got=%0d want=%0d", d, n, nw, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < nw; i++) begin
         total++;
         if (obs_q[bw+i] !== exp_q[i]) begin
            bad++; $display("FAIL xfer_write[%0d] dir=%0d n=%0d got=(%h,%h) want=(%h,%h)", i, d, n,
                            obs_q[bw+i].a, obs_q[bw+i].d, exp_q[i].a, exp_q[i].d);
         end
      end
      for (int k = 0; k < (d ? 5 : 1) && k < nw; k++) begin
         total++;
         if (obs_cyc[bw+k] != c0 + 1 + k) begin
            bad++; $display("FAIL xfer_latency[%0d] got=%0d want=%0d", k, obs_cyc[bw+k] - c0, 1 + k);
         end
      end
      total++; if (exits - bx != ne)      begin bad++; $display("FAIL xfer_wait_exits got=%0d want=%0d", exits - bx, ne); end
      total++; if (ready_rise - br != ne) begin bad++; $display("FAIL xfer_blk_ready got=%0d want=%0d", ready_rise - br, ne); end
      total++; if (done_cnt - bd != 1)    begin bad++; $display("FAIL xfer_done_pulses got=%0d want=1", done_cnt - bd); end
   endtask

   task automatic test_abort_with_flag();
      bit d  = 1'($urandom);
      int bw = obs_q.size();
      int bd = done_cnt;
      int br = ready_rise;
      int nw;
      bit seen = 1'b0;
      build_abort_exp(d);
      resp_hold = 1'b1;
      start = 1'b1; dir = d; nblocks = 8'($urandom_range(2, 9));
      step();
      start = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         if (reg_a == 4'd6 && !reg_we) seen = 1'b1;
         else step();
      end
      total++;
      if (!seen) begin bad++; $display("FAIL abort_reach_wait got=no_wait want=wait_data"); end
      flag_task = 1'b1; abort = 1'b1;
      step();
      flag_task = 1'b0; abort = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (done) seen = 1'b1;
         else step();
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL abort_timeout got=no_done want=done");
      end else begin
         total++; if (err !== 1'b1) begin bad++; $display("FAIL abort_err got=%b want=1", err); end
      end
      repeat (4) step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b want=0", busy); end
      total++; if (err !== 1'b1)  begin bad++; $display("FAIL abort_err_held got=%b want=1", err); end
      nw = obs_q.size() - bw;
      total++; if (nw != exp_q.size()) begin bad++; $display("FAIL abort_nwrites got=%0d want=%0d", nw, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < nw; i++) begin
         total++;
         if (obs_q[bw+i] !== exp_q[i]) begin
            bad++; $display("FAIL abort_write[%0d] got=(%h,%h) want=(%h,%h)", i,
                            obs_q[bw+i].a, obs_q[bw+i].d, exp_q[i].a, exp_q[i].d);
         end
      end
      total++; if (done_cnt - bd != 1)           begin bad++; $display("FAIL abort_done_pulses got=%0d want=1", done_cnt - bd); end
      total++; if (ready_rise - br != (d ? 0 : 1)) begin bad++; $display("FAIL abort_blk_ready got=%0d want=%0d", ready_rise - br, d ? 0 : 1); end
      resp_hold = 1'b0;
   endtask

   task automatic test_reset_mid_xfer();
      int bw = obs_q.size();
      int bd = done_cnt;
      bit seen = 1'b0;
      start = 1'b1; dir = 1'b1; nblocks = 8'd3;
      step();
      start = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (reg_we && reg_a == 4'd5) seen = 1'b1;
         else step();
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rstmid_reach_tgt got=no_write want=iotarget"); end
      rst_ = 1'b0;
      step();
      total++;
      if ({busy, done, err, blk_ready, reg_we, reg_a, reg_wd} !== 17'd0) begin
         bad++; $display("FAIL rstmid_outputs got=%h want=0", {busy, done, err, blk_ready, reg_we, reg_a, reg_wd});
      end
      step();
      rst_ = 1'b1;
      repeat (20) step();
      total++; if (obs_q.size() - bw != 3) begin bad++; $display("FAIL rstmid_nwrites got=%0d want=3", obs_q.size() - bw); end
      total++; if (done_cnt != bd)         begin bad++; $display("FAIL rstmid_done got=%0d want=0", done_cnt - bd); end
      total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
   endtask

`ifdef IDE_XFER_TIMEOUT_EN
   task automatic test_timeout();
      bit d  = 1'($urandom);
      int bw = obs_q.size();
      int bwc = wait_cycles;
      int nw;
      bit seen = 1'b0;
      build_abort_exp(d);
      resp_hold = 1'b1;
      start = 1'b1; dir = d; nblocks = 8'd1;
      step();
      start = 1'b0;
      for (int k = 0; k < TMO + 60 && !seen; k++) begin
         step();
         if (done) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL tmo_no_done got=no_done want=done");
      end else begin
         total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b want=1", err); end
      end
      repeat (3) step();
      total++; if (wait_cycles - bwc != TMO) begin bad++; $display("FAIL tmo_wait_cycles got=%0d want=%0d", wait_cycles - bwc, TMO); end
      nw = obs_q.size() - bw;
      total++; if (nw != exp_q.size()) begin bad++; $display("FAIL tmo_nwrites got=%0d want=%0d", nw, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < nw; i++) begin
         total++;
         if (obs_q[bw+i] !== exp_q[i]) begin
            bad++; $display("FAIL tmo_write[%0d] got=(%h,%h) want=(%h,%h)", i,
                            obs_q[bw+i].a, obs_q[bw+i].d, exp_q[i].a, exp_q[i].d);
         end
      end
      resp_hold = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_abort_idle();
      test_xfer(1'b1, 1);
      test_xfer(1'b0, 2);
      test_abort_with_flag();
      test_abort_idle();
      test_xfer(1'b0, 0);
      for (int r = 0; r < 4; r++) test_xfer(1'($urandom), $urandom_range(1, 6));
      test_xfer(1'b1, 3);
      test_reset_mid_xfer();
`ifdef IDE_XFER_TIMEOUT_EN
      test_timeout();
`endif
      test_xfer(1'b1, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
